frame_column_writer: RTL and testbench

//   Driving end of the tile configuration port for one fabric column. Accepts a

---
 rtl/frame_column_writer_pkg.sv | 23 ++
 rtl/frame_column_writer_if.sv | 14 +
 rtl/frame_column_writer_decoder.sv | 34 +++
 rtl/frame_column_writer.sv | 110 +++++++++++
 tb/tb_frame_column_writer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_column_writer_pkg.sv
// rtl/frame_column_writer_pkg.sv - shared types and constants for the frame column writer
// Purpose: FSM state encoding, header field layout and the frame index range check
//          shared by the top module and the strobe decoder.
// Ports:   none (package).
package frame_column_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } fsm_state_e;

  // Header word layout: [7:0] frame index, [15:8] column ID, rest ignored.
  localparam int IDX_LSB = 0;
  localparam int COL_LSB = 8;
  localparam int FIELD_W = 8;

  function automatic logic idx_in_range(input logic [FIELD_W-1:0] idx, input int max_frames);
    return int'(idx) < max_frames;
  endfunction

endpackage

// File: rtl/frame_column_writer_if.sv
// rtl/frame_column_writer_if.sv - bitstream word stream into the frame column writer
// Purpose: valid/ready word stream carrying header and row data words.
// Ports:   s_data (word), s_valid (source has a word), s_ready (sink accepts);
//          master = bitstream source, slave = frame_column_writer.
interface frame_column_writer_if #(
  parameter int W = 32
);
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_column_writer_decoder.sv
// rtl/frame_column_writer_decoder.sv - registered frame index to one-hot strobe decoder
// Purpose: on fire, turns the latched frame index into a one-cycle one-hot FrameStrobe,
//          or a one-cycle err pulse when the index is beyond the column's frame count.
// Ports:   clk, rst (sync active-high), fire (last row accepted), hit (column matched),
//          idx (frame index), strobe (one-hot, registered), err (registered pulse).
module frame_strobe_decoder
  import frame_column_writer_pkg::*;
#(
  parameter int MaxFramesPerCol = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fire,
  input  logic                       hit,
  input  logic [FIELD_W-1:0]         idx,
  output logic [MaxFramesPerCol-1:0] strobe,
  output logic                       err
);

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= '0;
      err    <= 1'b0;
    end else begin
      // Default-to-zero every cycle makes the strobe self-clearing after one cycle.
      // An out-of-range index matches no bit, so the strobe stays all zero.
      err <= fire & hit & ~idx_in_range(idx, MaxFramesPerCol);
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        strobe[i] <= fire & hit & (int'(idx) == i);
      end
    end
  end

endmodule

// File: rtl/frame_column_writer.sv
// rtl/frame_column_writer.sv - assembles one configuration frame per column and strobes it
// Purpose: takes a header word plus NumRows row words, builds FrameData, then fires a
//          one-cycle one-hot FrameStrobe for the addressed frame.
// Ports:   CLK, Reset (sync active-high), s (stream slave: s_data/s_valid/s_ready),
//          FrameData (row r at [r*FrameBitsPerRow +: FrameBitsPerRow]), FrameStrobe (one-hot),
//          busy (not IDLE), err_index (bad index pulse), frame_count (strobes issued, wraps).
module frame_column_writer
  import frame_column_writer_pkg::*;
#(
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter int          NumRows         = 16,
  parameter logic [7:0]  ColumnID        = 8'd0
) (
  input  logic                                CLK,
  input  logic                                Reset,
  frame_column_writer_if.slave                s,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                busy,
  output logic                                err_index,
  output logic [15:0]                         frame_count
);

  localparam int RowCntW = (NumRows > 1) ? $clog2(NumRows) : 1;

  fsm_state_e          state;
  logic [RowCntW-1:0]  row_cnt;
  logic [FIELD_W-1:0]  idx_q;
  logic                hit_q;
  logic                ready_q;
  logic                accept;
  logic                last_row;

  // ready_q tracks whether the next state accepts words; Reset forces s_ready low at once.
  assign s.s_ready = ready_q & ~Reset;
  assign accept    = s.s_valid & s.s_ready;
  assign last_row  = (state == ST_LOAD) && accept && (row_cnt == RowCntW'(NumRows - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      row_cnt     <= '0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      FrameData   <= '0;
      frame_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= s.s_data[IDX_LSB +: FIELD_W];
            hit_q   <= (s.s_data[COL_LSB +: FIELD_W] == ColumnID);
            row_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            // A missed frame still consumes its rows but leaves FrameData untouched.
            for (int r = 0; r < NumRows; r++) begin
              if (hit_q && row_cnt == RowCntW'(r)) begin
                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s.s_data;
              end
            end
            row_cnt <= row_cnt + 1'b1;
            if (last_row) begin
              // Strobe is registered on this same edge by the decoder, so the
              // count moves together with it.
              ready_q <= 1'b0;
              state   <= ST_STROBE;
              if (hit_q && idx_in_range(idx_q, MaxFramesPerCol)) begin
                frame_count <= frame_count + 16'd1;
              end
            end
          end
        end
        ST_STROBE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_decoder (
    .clk   (CLK),
    .rst   (Reset),
    .fire  (last_row),
    .hit   (hit_q),
    .idx   (idx_q),
    .strobe(FrameStrobe),
    .err   (err_index)
  );

endmodule

// File: tb/tb_frame_column_writer.sv
// tb/tb_frame_column_writer.sv - self-checking bench for frame_column_writer
module tb_frame_column_writer;

  localparam int ROWS = 16;
  localparam int MAXF = 20;
  localparam int W    = 32;
  localparam logic [7:0] COL = 8'h00;

  logic                  CLK;
  logic                  Reset;
  logic [ROWS*W-1:0]     FrameData;
  logic [MAXF-1:0]       FrameStrobe;
  logic                  busy;
  logic                  err_index;
  logic [15:0]           frame_count;

  frame_column_writer_if #(.W(W)) tif ();

  frame_column_writer #(
    .MaxFramesPerCol(MAXF), .FrameBitsPerRow(W), .NumRows(ROWS), .ColumnID(COL)
  ) dut (
    .CLK(CLK), .Reset(Reset), .s(tif), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .err_index(err_index), .frame_count(frame_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_on   = 0;
  int strobe_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: words accepted so far, rows stored, strobes per completed frame.
  logic        m_ready, m_busy, m_err, m_hit;
  logic [MAXF-1:0] m_strobe;
  logic [15:0] m_cnt;
  logic [7:0]  m_idx;
  logic [31:0] m_row [ROWS];
  int          m_rows, m_after;

  always @(posedge CLK) begin
    cyc++;
    m_strobe = '0;
    m_err    = 1'b0;
    if (Reset) begin
      m_ready = 1'b1; m_busy = 1'b0; m_rows = -1; m_after = 0; m_cnt = 16'd0;
      m_idx = 8'd0; m_hit = 1'b0;
      for (int r = 0; r < ROWS; r++) m_row[r] = 32'd0;
    end else if (m_after > 0) begin
      m_after--;
      if (m_after == 0) begin m_ready = 1'b1; m_busy = 1'b0; end
    end else if (tif.s_valid && m_ready) begin
      if (m_rows < 0) begin
        m_idx = tif.s_data[7:0];
        m_hit = (tif.s_data[15:8] == COL);
        m_rows = 0;
        m_busy = 1'b1;
      end else begin
        if (m_hit) m_row[m_rows] = tif.s_data;
        m_rows++;
        if (m_rows == ROWS) begin
          m_rows = -1; m_ready = 1'b0; m_after = 2;
          if (m_hit && m_idx < MAXF) begin
            m_strobe = MAXF'(1) << m_idx;
            m_cnt++;
          end else if (m_hit) begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    #2;
    if (chk_on) begin
      int bad;
      bad = 0;
      chk("s_ready", 32'(tif.s_ready), 32'(m_ready && !Reset));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_strobe", 32'(FrameStrobe), 32'(m_strobe));
      chk("err_index", 32'(err_index), 32'(m_err));
      chk("frame_count", 32'(frame_count), 32'(m_cnt));
      for (int r = ROWS - 1; r >= 0; r--)
        if (FrameData[r*W +: W] !== m_row[r]) bad = r;
      chk("frame_data", FrameData[bad*W +: W], m_row[bad]);
      if (FrameStrobe != '0) strobe_cyc.push_back(cyc);
    end
  end

  task automatic put_word(input logic [31:0] w);
    int waited;
    waited = 0;
    @(negedge CLK);
    tif.s_valid = 1'b1;
    tif.s_data  = w;
    #1;
    while (!tif.s_ready) begin
      waited++;
      if (waited > 40) begin
        n_checks++; n_fail++;
        $display("FAIL put_timeout t=%0t actual=s_ready_low expected=s_ready_high", $time);
        tif.s_valid = 1'b0;
        return;
      end
      @(negedge CLK);
      #1;
    end
    @(posedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      tif.s_valid = 1'b0;
      tif.s_data  = $urandom;
    end
  endtask

  task automatic send_frame(input logic [7:0] col, input logic [7:0] idx, input int gaps);
    put_word({16'h5A5A, col, idx});
    for (int r = 0; r < ROWS; r++) begin
      if (gaps != 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      put_word($urandom);
    end
  endtask

  task automatic at_next_neg();
    @(negedge CLK);
    #3;
  endtask

  initial begin
    Reset = 1'b1;
    tif.s_valid = 1'b0;
    tif.s_data  = 32'd0;
    repeat (2) @(negedge CLK);
    chk_on = 1;
    #3;
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_strobe", 32'(FrameStrobe), 32'd0);
    chk("rst_s_ready", 32'(tif.s_ready), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // 1) basic frame idx 3
    put_word(32'h0000_0003);
    for (int r = 0; r < ROWS; r++) put_word(32'hA5A5_0000 + r);
    idle(0);
    at_next_neg();
    chk("t1_strobe", 32'(FrameStrobe), 32'h0000_0008);
    chk("t1_count", 32'(frame_count), 32'd1);
    chk("t1_row15", FrameData[15*W +: W], 32'hA5A5_000F);
    chk("t1_ready_strobe", 32'(tif.s_ready), 32'd0);
    tif.s_valid = 1'b0;
    at_next_neg();
    chk("t1_strobe_off", 32'(FrameStrobe), 32'd0);
    chk("t1_busy_hold", 32'(busy), 32'd1);
    at_next_neg();
    chk("t1_ready_back", 32'(tif.s_ready), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 2) other column: rows consumed, nothing written
    send_frame(8'h05, 8'h02, 0);
    at_next_neg();
    chk("t2_ready_low1", 32'(tif.s_ready), 32'd0);
    chk("t2_no_strobe", 32'(FrameStrobe), 32'd0);
    tif.s_valid = 1'b0;
    at_next_neg();
    chk("t2_ready_low2", 32'(tif.s_ready), 32'd0);
    chk("t2_row3_kept", FrameData[3*W +: W], 32'hA5A5_0003);
    chk("t2_count", 32'(frame_count), 32'd1);

    // 3) index just out of range
    send_frame(COL, 8'd20, 0);
    at_next_neg();
    chk("t3_err", 32'(err_index), 32'd1);
    chk("t3_no_strobe", 32'(FrameStrobe), 32'd0);
    tif.s_valid = 1'b0;
    at_next_neg();
    chk("t3_err_off", 32'(err_index), 32'd0);
    chk("t3_count", 32'(frame_count), 32'd1);

    // 4) random frames with valid gaps
    for (int f = 0; f < 30; f++) begin
      send_frame(($urandom_range(0, 3) == 0) ? 8'h05 : COL, 8'($urandom_range(0, 22)), 1);
      idle($urandom_range(0, 4));
    end
    idle(3);

    // 5) reset mid-LOAD of idx 7
    put_word(32'h0000_0007);
    for (int r = 0; r < 5; r++) put_word($urandom);
    @(negedge CLK);
    tif.s_valid = 1'b0;
    Reset = 1'b1;
    at_next_neg();
    chk("t5_data_cleared", FrameData[0 +: W], 32'd0);
    chk("t5_no_strobe", 32'(FrameStrobe), 32'd0);
    chk("t5_count_cleared", 32'(frame_count), 32'd0);
    Reset = 1'b0;
    send_frame(COL, 8'd7, 0);
    at_next_neg();
    chk("t5_strobe7", 32'(FrameStrobe), 32'h0000_0080);
    chk("t5_count", 32'(frame_count), 32'd1);
    tif.s_valid = 1'b0;
    idle(3);

    // 6) counter wrap, then back-to-back throughput
    @(negedge CLK);
    force dut.frame_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge CLK);
    release dut.frame_count;
    send_frame(COL, 8'd1, 0);
    at_next_neg();
    chk("t6_wrap", 32'(frame_count), 32'd0);
    strobe_cyc.delete();
    for (int f = 0; f < 3; f++) send_frame(COL, 8'(f + 10), 0);
    idle(4);
    chk("t6_strobes", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      chk("t6_period_a", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(ROWS + 3));
      chk("t6_period_b", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'(ROWS + 3));
    end
    chk("t6_count", 32'(frame_count), 32'd3);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout t=%0t actual=running expected=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
